// File: rtl/jtpang_bank_slots_if.sv
`default_nettype none
// =============================================================================
// jtpang_bank_slots_if
// One SDRAM bank lane: request address/strobe out, ack/dst/rdy/data back.
// Revision: 1.0
// =============================================================================
interface jtpang_bank_slots_if;
    logic [21:0] ba_addr;
    logic        ba_rd;
    logic        ba_ack;
    logic        ba_dst;
    logic        ba_rdy;
    logic [15:0] data_read;

    modport master (
        output ba_addr,
        output ba_rd,
        input  ba_ack,
        input  ba_dst,
        input  ba_rdy,
        input  data_read
    );

    modport slave (
        input  ba_addr,
        input  ba_rd,
        output ba_ack,
        output ba_dst,
        output ba_rdy,
        output data_read
    );
endinterface
`default_nettype wire

// File: rtl/jtpang_bank_slots.sv
`default_nettype none
// =============================================================================
// jtpang_bank_slots
// Round-robin SDRAM bank front-end with a one-entry cache per ROM client slot.
// Revision: 1.0
// =============================================================================
module jtpang_bank_slots #(
    parameter int                  SLOTS   = 4,
    parameter int                  AW      = 20,
    parameter int                  DW      = 8,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    downloading,
    input  wire  [SLOTS*AW-1:0]    slot_addr,
    input  wire  [SLOTS-1:0]       slot_cs,
    output logic [SLOTS-1:0]       slot_ok,
    output logic [SLOTS*DW-1:0]    slot_dout,
    jtpang_bank_slots_if.master    ba
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int WA = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ba_rd_q, ba_rd_d;
    logic [21:0]       ba_addr_q, ba_addr_d;
    logic [IW-1:0]     sel_q, sel_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [15:0]       low_q, low_d;
    logic [SLOTS-1:0]  valid_q, valid_d;
    logic [AW-1:0]     tag_q  [SLOTS];
    logic [AW-1:0]     tag_d  [SLOTS];
    logic [DW-1:0]     dout_q [SLOTS];
    logic [DW-1:0]     dout_d [SLOTS];

    logic [AW-1:0]     addr_w   [SLOTS];
    logic [21:0]       offset_w [SLOTS];
    logic [SLOTS-1:0]  pending;

    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand;
    logic [AW-1:0]     gaddr;
    logic [WA-1:0]     gword;
    logic [21:0]       gsdram;
    logic [31:0]       word32;
    logic [7:0]        byte_sel;
    logic [DW-1:0]     fill;

    // slot_ok is gated by downloading so no client ever sees a hit during a load
    generate
        for (genvar i = 0; i < SLOTS; i++) begin : g_slot
            assign addr_w[i]              = slot_addr[i*AW +: AW];
            assign offset_w[i]            = OFFSETS[i*22 +: 22];
            assign slot_ok[i]             = slot_cs[i] & valid_q[i] & ~downloading
                                            & (addr_w[i] == tag_q[i]);
            assign slot_dout[i*DW +: DW]  = dout_q[i];
        end
    endgenerate

    assign pending = slot_cs & ~slot_ok;

    // First pending slot at or after the round-robin pointer, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand        = '0;
        for (int k = 0; k < SLOTS; k++) begin
            cand = IW'((int'(ptr_q) + k) % SLOTS);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        gaddr = addr_w[grant_idx];
        case (DW)
            8:       gword = WA'(gaddr >> 1);
            16:      gword = WA'(gaddr);
            default: gword = {gaddr, 1'b0};
        endcase
        gsdram = 22'(gword) + offset_w[grant_idx];
    end

    // With dst and rdy together both halves come from the same word
    always_comb begin
        word32   = {ba.data_read, (ba.ba_dst ? ba.data_read : low_q)};
        byte_sel = addr_q[0] ? ba.data_read[15:8] : ba.data_read[7:0];
        case (DW)
            8:       fill = DW'(byte_sel);
            16:      fill = DW'(ba.data_read);
            default: fill = DW'(word32);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ba_rd_d   = ba_rd_q;
        ba_addr_d = ba_addr_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        low_d     = low_q;
        valid_d   = downloading ? '0 : valid_q;
        tag_d     = tag_q;
        dout_d    = dout_q;

        case (state_q)
            S_IDLE: begin
                if (!downloading && grant_found) begin
                    sel_d     = grant_idx;
                    addr_d    = gaddr;
                    ba_addr_d = gsdram;
                    ba_rd_d   = 1'b1;
                    state_d   = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ba.ba_ack) begin
                    ba_rd_d = 1'b0;
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (DW == 32 && ba.ba_dst) begin
                    low_d = ba.data_read;
                end
                if (ba.ba_rdy) begin
                    dout_d[sel_q]  = fill;
                    tag_d[sel_q]   = addr_q;
                    valid_d[sel_q] = ~downloading;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = (sel_q == IW'(SLOTS - 1)) ? '0 : sel_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ba_rd_q   <= 1'b0;
            ba_addr_q <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            low_q     <= '0;
            valid_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ba_rd_q   <= ba_rd_d;
            ba_addr_q <= ba_addr_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            low_q     <= low_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            dout_q    <= dout_d;
        end
    end

    assign ba.ba_rd   = ba_rd_q;
    assign ba.ba_addr = ba_addr_q;

endmodule
`default_nettype wire
